// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the staggered reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        S_ASSERT  = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    // The counter must hold the ASSERT_CYCLES terminal value as well as the stagger span.
    function automatic int cnt_width(input int assert_cycles, input int stagger_cycles);
        int m;
        m = (assert_cycles > stagger_cycles) ? assert_cycles : stagger_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sync_cell.sv
// Multi-flop synchronizer bringing the asynchronous reset request into the clk domain.
module reset_sync_cell #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) r_chain[0] <= 1'b0;
        else     r_chain[0] <= i_async;
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (rst) r_chain[gi] <= 1'b0;
                else     r_chain[gi] <= r_chain[gi-1];
            end
        end
    endgenerate

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Holds all reset domains asserted for a programmable time, then releases them
// one by one in index order with a fixed stagger, all synchronous to clk.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_DOMAINS      = 3,
    parameter int ASSERT_CYCLES  = 8,
    parameter int STAGGER_CYCLES = 4,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ext_req_async,
    input  logic                 sw_req,
    output logic                 sw_ack,
    output logic [N_DOMAINS-1:0] dom_rst,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = cnt_width(ASSERT_CYCLES, STAGGER_CYCLES);
    localparam int IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
    localparam logic [CW-1:0]        A_END = CW'(ASSERT_CYCLES);
    localparam logic [CW-1:0]        S_END = CW'(STAGGER_CYCLES - 1);
    localparam logic [IW-1:0]        LAST  = IW'(N_DOMAINS - 1);
    localparam logic [N_DOMAINS-1:0] BIT0  = N_DOMAINS'(1);

    logic                 w_ext_sync;
    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [N_DOMAINS-1:0] r_dom_rst;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_sw_ack;
    logic                 r_src_sw;
    logic                 r_pend;

    reset_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (ext_req_async),
        .o_sync  (w_ext_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_ASSERT;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_dom_rst <= '1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_sw_ack  <= 1'b0;
            r_src_sw  <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            r_done   <= r_pend;
            r_sw_ack <= r_pend & r_src_sw;
            r_pend   <= 1'b0;
            case (r_state)
                S_ASSERT: begin
                    r_dom_rst <= '1;
                    r_busy    <= 1'b1;
                    // The count covers the full assertion window, so the first
                    // release lands ASSERT_CYCLES edges after counting begins.
                    if (w_ext_sync) begin
                        r_cnt <= '0;
                    end else if (r_cnt == A_END) begin
                        r_dom_rst <= ~BIT0;
                        r_cnt     <= '0;
                        if (N_DOMAINS == 1) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b0;
                            r_pend  <= 1'b1;
                        end else begin
                            r_idx   <= IW'(1);
                            r_state <= S_RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (w_ext_sync) begin
                        r_state   <= S_ASSERT;
                        r_dom_rst <= '1;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_idx     <= '0;
                    end else if (r_cnt == S_END) begin
                        r_dom_rst <= r_dom_rst & ~(BIT0 << r_idx);
                        r_cnt     <= '0;
                        r_idx     <= r_idx + 1'b1;
                        if (r_idx == LAST) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b0;
                            r_pend  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    r_dom_rst <= '0;
                    r_busy    <= 1'b0;
                    // sw_req is ignored on the edge that raises sw_ack, giving the
                    // requester one cycle to drop it.
                    if (w_ext_sync) begin
                        r_state   <= S_ASSERT;
                        r_dom_rst <= '1;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_idx     <= '0;
                        r_src_sw  <= 1'b0;
                    end else if (sw_req && !r_pend) begin
                        r_state   <= S_ASSERT;
                        r_dom_rst <= '1;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_idx     <= '0;
                        r_src_sw  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_ASSERT;
                    r_dom_rst <= '1;
                    r_busy    <= 1'b1;
                    r_cnt     <= '0;
                    r_idx     <= '0;
                end
            endcase
        end
    end

    assign dom_rst = r_dom_rst;
    assign busy    = r_busy;
    assign done    = r_done;
    assign sw_ack  = r_sw_ack;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized and directed bench for reset_sequencer against a timing-formula model.
module tb_reset_sequencer;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ext_req = 1'b0;
    logic       sw_req = 1'b0;
    logic       sw_ack_a, busy_a, done_a;
    logic [2:0] dom_a;
    logic       sw_ack_b, busy_b, done_b;
    logic [0:0] dom_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.N_DOMAINS(3), .ASSERT_CYCLES(8), .STAGGER_CYCLES(4), .SYNC_STAGES(SYNC)) dut_a (
        .clk(clk), .rst(rst), .ext_req_async(ext_req), .sw_req(sw_req),
        .sw_ack(sw_ack_a), .dom_rst(dom_a), .busy(busy_a), .done(done_a)
    );

    reset_sequencer #(.N_DOMAINS(1), .ASSERT_CYCLES(1), .STAGGER_CYCLES(4), .SYNC_STAGES(SYNC)) dut_b (
        .clk(clk), .rst(rst), .ext_req_async(ext_req), .sw_req(sw_req),
        .sw_ack(sw_ack_b), .dom_rst(dom_b), .busy(busy_b), .done(done_b)
    );

    // Model: t counts edges spent counting toward release since the hold started;
    // bit i is released once t exceeds ASSERT + i*STAGGER.
    typedef struct {
        bit active;
        int t;
        bit src;
        bit due;
        bit done;
        bit ack;
    } mstate_t;

    mstate_t         ma, mb;
    bit [SYNC-1:0]   hist;
    logic [2:0]      prev_a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mstate_t mstep(input mstate_t s, input bit r, input bit ext, input bit sw,
                                      input int n, input int a, input int st);
        mstate_t ns;
        ns      = s;
        ns.done = s.due;
        ns.ack  = s.due & s.src;
        ns.due  = 1'b0;
        if (r) begin
            ns.active = 1'b1; ns.t = 0; ns.src = 1'b0;
            ns.done = 1'b0; ns.ack = 1'b0;
        end else if (s.active) begin
            if (ext) begin
                ns.t = 0;
            end else begin
                ns.t = s.t + 1;
                if (ns.t == a + (n - 1) * st + 1) begin
                    ns.active = 1'b0;
                    ns.due    = 1'b1;
                end
            end
        end else if (ext) begin
            ns.active = 1'b1; ns.t = 0; ns.src = 1'b0;
        end else if (sw && !s.due) begin
            ns.active = 1'b1; ns.t = 0; ns.src = 1'b1;
        end
        return ns;
    endfunction

    function automatic logic [7:0] mdom(input mstate_t s, input int n, input int a, input int st);
        int k;
        logic [7:0] all;
        k   = 0;
        all = (8'd1 << n) - 8'd1;
        if (!s.active) return 8'd0;
        for (int i = 0; i < n; i++)
            if (s.t >= a + i * st + 1) k++;
        return all & ~((8'd1 << k) - 8'd1);
    endfunction

    function automatic logic order_bad(input logic [2:0] p, input logic [2:0] c);
        logic [2:0] fell, rose;
        logic v;
        fell = p & ~c;
        rose = ~p & c;
        v = (rose != 3'b000) && (c != 3'b111);
        for (int i = 1; i < 3; i++)
            for (int j = 0; j < i; j++)
                if (fell[i] && c[j]) v = 1'b1;
        return v;
    endfunction

    task automatic tick();
        mstate_t na, nb;
        bit es;
        logic [7:0] ed_a, ed_b;
        es = hist[SYNC-1];
        na = mstep(ma, rst, es, sw_req, 3, 8, 4);
        nb = mstep(mb, rst, es, sw_req, 1, 1, 4);
        hist = rst ? '0 : {hist[SYNC-2:0], ext_req};
        @(posedge clk);
        #1;
        ma = na;
        mb = nb;
        ed_a = mdom(ma, 3, 8, 4);
        ed_b = mdom(mb, 1, 1, 4);
        chk("dom_a",  {29'd0, dom_a},    {24'd0, ed_a});
        chk("busy_a", {31'd0, busy_a},   {31'd0, (ed_a != 8'd0)});
        chk("done_a", {31'd0, done_a},   {31'd0, ma.done});
        chk("ack_a",  {31'd0, sw_ack_a}, {31'd0, ma.ack});
        chk("dom_b",  {31'd0, dom_b},    {24'd0, ed_b});
        chk("busy_b", {31'd0, busy_b},   {31'd0, (ed_b != 8'd0)});
        chk("done_b", {31'd0, done_b},   {31'd0, mb.done});
        chk("ack_b",  {31'd0, sw_ack_b}, {31'd0, mb.ack});
        chk("order_a", {31'd0, order_bad(prev_a, dom_a)}, 32'd0);
        prev_a = dom_a;
        if (done_a) $display("seq done dut_a t=%0t sw_ack=%0b", $time, sw_ack_a);
    endtask

    task automatic wait_dom(input logic [2:0] tgt, input int max, input string tag);
        int n;
        n = 0;
        while (dom_a !== tgt && n < max) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, (n < max)}, 32'd1);
    endtask

    task automatic serve_sw(input int max, input string tag);
        int n;
        n = 0;
        sw_req = 1'b1;
        while (!sw_ack_a && n < max) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, sw_ack_a}, 32'd1);
        sw_req = 1'b0;
    endtask

    initial begin
        int ext_left;
        int ack_cnt;
        logic [2:0] exp_po;
        ma = '{active: 1'b1, t: 0, src: 1'b0, due: 1'b0, done: 1'b0, ack: 1'b0};
        mb = ma;
        hist = '0;
        prev_a = 3'b111;

        // Reset held for five cycles.
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_dom",  {29'd0, dom_a}, 32'd7);
        chk("rst_busy", {31'd0, busy_a}, 32'd1);

        // Power-on sequence, k is the edge index E(k).
        rst = 1'b0;
        ack_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_po = (k < 8) ? 3'b111 : (k < 12) ? 3'b110 : (k < 16) ? 3'b100 : 3'b000;
            chk("po_dom",  {29'd0, dom_a},  {29'd0, exp_po});
            chk("po_done", {31'd0, done_a}, {31'd0, (k == 17)});
            chk("po_dom_b",  {31'd0, dom_b},  {31'd0, (k < 1)});
            chk("po_done_b", {31'd0, done_b}, {31'd0, (k == 2)});
            if (sw_ack_a) ack_cnt++;
        end
        chk("po_no_ack", ack_cnt, 32'd0);

        // Software request from RUN.
        serve_sw(60, "sw_ack_seen");
        for (int i = 0; i < 6; i++) tick();
        chk("sw_stays_run", {29'd0, dom_a}, 32'd0);

        // External pulse during RELEASE after bit 0 released.
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        wait_dom(3'b110, 40, "wait_rel");
        ext_req = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        ext_req = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk("abort_recovered", {29'd0, dom_a}, 32'd0);

        // ext_sync and sw_req coincide in RUN: ext wins, sw served afterwards.
        ext_req = 1'b1;
        tick();
        tick();
        ext_req = 1'b0;
        sw_req  = 1'b1;
        ack_cnt = 0;
        for (int i = 0; i < 80 && !sw_ack_a; i++) begin
            tick();
            if (done_a) ack_cnt++;
        end
        chk("coincide_acked", {31'd0, sw_ack_a}, 32'd1);
        chk("coincide_dones", ack_cnt, 32'd2);
        sw_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // rst asserted mid-RELEASE.
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        wait_dom(3'b100, 40, "wait_100");
        rst = 1'b1;
        tick();
        chk("midrst_dom",  {29'd0, dom_a}, 32'd7);
        chk("midrst_busy", {31'd0, busy_a}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        chk("midrst_recover", {29'd0, dom_a}, 32'd0);

        // Randomized ext / sw / rst traffic.
        ext_left = 0;
        for (int c = 0; c < 1500; c++) begin
            if (ext_left > 0) begin
                ext_req = 1'b1;
                ext_left--;
            end else begin
                ext_req = 1'b0;
                if ($urandom_range(0, 59) == 0) ext_left = $urandom_range(1, 4);
            end
            if (!sw_req && $urandom_range(0, 29) == 0) sw_req = 1'b1;
            rst = ($urandom_range(0, 399) == 0);
            tick();
            if (sw_ack_a) sw_req = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
